// File: rtl/lpcm_monitor.sv
// ---------------------------------------------------------------------------
// LpcmMonitor (module lpcm_monitor)
//
// Passive sink that sits right behind the LPCM driver. Every strobed sample
// on the LPCM bus becomes an item {sample, latency}, where latency is the
// number of idle (en=0) cycles that came before it. Items are queued in a
// small FIFO and offered to the scoreboard over a valid/ready port.
//
// Ports:
//   clk          bus clock, everything happens on its rising edge
//   reset        asynchronous, active-high; empties the FIFO and clears state
//   lpcm_en      sample strobe from the LPCM bus
//   lpcm_data    sample value, meaningful only while lpcm_en=1
//   out_valid    the FIFO head holds an item
//   out_ready    the consumer takes the head item this cycle
//   out_sample   sample of the head item (0 while the FIFO is empty)
//   out_latency  idle-gap count of the head item (0 while the FIFO is empty)
//   out_count    number of items currently buffered
//   overflow     sticky flag: a sample arrived while the FIFO was full
// ---------------------------------------------------------------------------
module lpcm_monitor #(
    parameter int DATA_W     = 16,
    parameter int LAT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          lpcm_en,
    input  logic [DATA_W-1:0]             lpcm_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_sample,
    output logic [LAT_W-1:0]              out_latency,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LAT_W-1:0] GAP_MAX = '1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [LAT_W-1:0]  gap_q, gap_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] sampleMem [FIFO_DEPTH];
    logic [LAT_W-1:0]  latMem    [FIFO_DEPTH];

    logic full;
    logic pop;
    logic push;
    logic drop;

    // Next-state logic. A pop frees the head slot in the same edge, so a strobe
    // arriving while full can still be accepted when the consumer is taking an
    // item; only a strobe into a full FIFO with no pop is dropped. The gap
    // counter restarts on every strobe, whether or not the sample was kept.
    always_comb begin
        full       = (count_q == DEPTH_C);
        pop        = (count_q != '0) && out_ready;
        push       = lpcm_en && (!full || pop);
        drop       = lpcm_en && full && !pop;

        gap_d      = gap_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;

        if (lpcm_en) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end

        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers, occupancy, gap counter and the sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q      <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            gap_q      <= gap_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Item storage. It needs no reset because nothing is read from it while
    // the FIFO is empty; the outputs below are forced to 0 in that case.
    always_ff @(posedge clk) begin
        if (push) begin
            sampleMem[wrPtr_q] <= lpcm_data;
            latMem[wrPtr_q]    <= gap_q;
        end
    end

    // Head-of-FIFO presentation, driven purely from registered state.
    always_comb begin
        out_valid   = (count_q != '0);
        out_sample  = out_valid ? sampleMem[rdPtr_q] : '0;
        out_latency = out_valid ? latMem[rdPtr_q]    : '0;
        out_count   = count_q;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_lpcm_monitor.sv
// ---------------------------------------------------------------------------
// tb_lpcm_monitor
//
// Directed bench for lpcm_monitor with default parameters
// (DATA_W=16, LAT_W=8, FIFO_DEPTH=4). Inputs change 1 ns after a rising
// edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_lpcm_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lpcm_en;
    logic [15:0] lpcm_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic [7:0]  out_latency;
    logic [2:0]  out_count;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] dVec [5];
    logic [15:0] eVec [5];

    lpcm_monitor #(
        .DATA_W(16),
        .LAT_W(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lpcm_en(lpcm_en),
        .lpcm_data(lpcm_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sample(out_sample),
        .out_latency(out_latency),
        .out_count(out_count),
        .overflow(overflow)
    );

    // 10 ns bus clock.
    always #5 clk = ~clk;

    // Drive one cycle of bus/consumer inputs, then step past the next edge.
    // Idle cycles put random junk on the data bus, as the real driver does.
    task automatic applyStimulus(input logic en, input logic [15:0] data, input logic ready);
        lpcm_en   = en;
        lpcm_data = en ? data : 16'($urandom);
        out_ready = ready;
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        dVec = '{16'hD000, 16'hD111, 16'hD222, 16'hD333, 16'hD444};
        eVec = '{16'hE000, 16'hE111, 16'hE222, 16'hE333, 16'hE444};

        reset     = 1'b1;
        lpcm_en   = 1'b0;
        lpcm_data = 16'h0;
        out_ready = 1'b0;

        // Reset state.
        #3;
        checkOutput("rst_valid",    32'(out_valid),   32'd0);
        checkOutput("rst_count",    32'(out_count),   32'd0);
        checkOutput("rst_overflow", 32'(overflow),    32'd0);
        checkOutput("rst_sample",   32'(out_sample),  32'd0);
        checkOutput("rst_latency",  32'(out_latency), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Step 1: three idle cycles, then a strobe with 0x1234 -> latency 3.
        repeat (3) applyStimulus(1'b0, 16'h0, 1'b0);
        lpcm_en   = 1'b1;
        lpcm_data = 16'h1234;
        #1;
        checkOutput("s1_no_comb_path", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 16'h1234, 1'b0);
        checkOutput("s1_valid",   32'(out_valid),   32'd1);
        checkOutput("s1_sample",  32'(out_sample),  32'h1234);
        checkOutput("s1_latency", 32'(out_latency), 32'd3);
        checkOutput("s1_count",   32'(out_count),   32'd1);

        // Step 2: back-to-back strobes A,B,C while the consumer pops each edge.
        applyStimulus(1'b1, 16'hAAAA, 1'b1);
        checkOutput("s2_A_sample",  32'(out_sample),  32'hAAAA);
        checkOutput("s2_A_latency", 32'(out_latency), 32'd0);
        checkOutput("s2_A_count",   32'(out_count),   32'd1);
        applyStimulus(1'b1, 16'hBBBB, 1'b1);
        checkOutput("s2_B_sample",  32'(out_sample),  32'hBBBB);
        checkOutput("s2_B_latency", 32'(out_latency), 32'd0);
        checkOutput("s2_B_count",   32'(out_count),   32'd1);
        applyStimulus(1'b1, 16'hCCCC, 1'b1);
        checkOutput("s2_C_sample",  32'(out_sample),  32'hCCCC);
        checkOutput("s2_C_latency", 32'(out_latency), 32'd0);
        checkOutput("s2_C_count",   32'(out_count),   32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("s2_empty_valid", 32'(out_valid), 32'd0);
        checkOutput("s2_empty_count", 32'(out_count), 32'd0);

        // Step 3: five strobes with no consumer. One idle cycle precedes D0.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, dVec[i], 1'b0);
            checkOutput($sformatf("s3_fill_count_%0d", i), 32'(out_count), (i < 4) ? 32'(i + 1) : 32'd4);
            checkOutput($sformatf("s3_hold_head_%0d", i),  32'(out_sample), 32'hD000);
        end
        checkOutput("s3_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            lpcm_en = 1'b0;
            #1;
            checkOutput($sformatf("s3_drain_sample_%0d", i),  32'(out_sample),  32'(dVec[i]));
            checkOutput($sformatf("s3_drain_latency_%0d", i), 32'(out_latency), (i == 0) ? 32'd1 : 32'd0);
            applyStimulus(1'b0, 16'h0, 1'b1);
        end
        checkOutput("s3_drained_count",  32'(out_count), 32'd0);
        checkOutput("s3_overflow_stays", 32'(overflow),  32'd1);

        // Reset clears the sticky flag; released one edge later with gap 0.
        reset = 1'b1;
        #1;
        checkOutput("rst2_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Step 4: fill to 4, then strobe E4 while popping -> accepted, count 4.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, eVec[i], 1'b0);
        end
        checkOutput("s4_full_count", 32'(out_count), 32'd4);
        applyStimulus(1'b1, eVec[4], 1'b1);
        checkOutput("s4_push_pop_count",    32'(out_count), 32'd4);
        checkOutput("s4_push_pop_overflow", 32'(overflow),  32'd0);
        for (int i = 1; i < 5; i++) begin
            lpcm_en = 1'b0;
            #1;
            checkOutput($sformatf("s4_drain_sample_%0d", i),  32'(out_sample),  32'(eVec[i]));
            checkOutput($sformatf("s4_drain_latency_%0d", i), 32'(out_latency), 32'd0);
            applyStimulus(1'b0, 16'h0, 1'b1);
        end
        checkOutput("s4_drained_count", 32'(out_count), 32'd0);

        // Step 6: three items buffered (F0 sees the 4 drain cycles as its gap),
        // then reset asserted between clock edges.
        applyStimulus(1'b1, 16'hF000, 1'b0);
        checkOutput("s6_F0_latency", 32'(out_latency), 32'd4);
        applyStimulus(1'b1, 16'hF111, 1'b0);
        applyStimulus(1'b1, 16'hF222, 1'b0);
        checkOutput("s6_count3", 32'(out_count), 32'd3);
        lpcm_en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("s6_async_valid",    32'(out_valid), 32'd0);
        checkOutput("s6_async_count",    32'(out_count), 32'd0);
        checkOutput("s6_async_overflow", 32'(overflow),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Step 5: 300 idle cycles saturate the 8-bit gap at 255.
        repeat (300) applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h5555, 1'b0);
        checkOutput("s5_valid",   32'(out_valid),   32'd1);
        checkOutput("s5_sample",  32'(out_sample),  32'h5555);
        checkOutput("s5_latency", 32'(out_latency), 32'd255);
        checkOutput("s5_count",   32'(out_count),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
